// File: rtl/stream_demux_if.sv
// -----------------------------------------------------------------------------
// stream_demux_if
//
// Purpose:
//   Bundles the producer-side and consumer-side handshake signals of
//   stream_demux into one interface. It is parameterised with the same values
//   as the demux instance it connects to.
//
// Signals:
//   in_valid   producer -> demux  input beat present
//   in_ready   demux -> producer  beat accepted when in_valid && in_ready
//   in_sel     producer -> demux  destination channel (SEL_W bits)
//   in_data    producer -> demux  payload (WIDTH bits)
//   out_valid  demux -> consumers bit c: channel c holds a beat
//   out_ready  consumers -> demux bit c: consumer c accepts this cycle
//   out_data   demux -> consumers channel c payload at [c*WIDTH +: WIDTH]
//   drop_count demux -> observer  saturating count of out-of-range beats
//
// Modports:
//   master  environment view (producer, consumers, observer)
//   slave   demux view
// -----------------------------------------------------------------------------
interface stream_demux_if #(
    parameter int WIDTH   = 8,
    parameter int NUM_OUT = 4,
    parameter int CNT_W   = 8
);
    // Derived from NUM_OUT; never set independently.
    localparam int SEL_W = $clog2(NUM_OUT);

    logic                       in_valid;
    logic                       in_ready;
    logic [SEL_W-1:0]           in_sel;
    logic [WIDTH-1:0]           in_data;
    logic [NUM_OUT-1:0]         out_valid;
    logic [NUM_OUT-1:0]         out_ready;
    logic [NUM_OUT*WIDTH-1:0]   out_data;
    logic [CNT_W-1:0]           drop_count;

    modport master (
        output in_valid,
        output in_sel,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  drop_count
    );

    modport slave (
        input  in_valid,
        input  in_sel,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output drop_count
    );
endinterface

// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
//
// Purpose:
//   1-to-NUM_OUT stream demultiplexer with valid/ready handshaking. Every input
//   beat carries a channel select and is steered into a one-entry output
//   register on that channel, where it waits until the channel's consumer
//   takes it. Beats whose select is out of range are swallowed and counted.
//
// Ports:
//   i_clk   clock, all logic on the rising edge
//   i_rst   synchronous reset, active high
//   io_bus  stream_demux_if.slave: in_valid/in_ready/in_sel/in_data from the
//           producer, out_valid/out_ready/out_data per consumer channel, and
//           drop_count
//
// Behaviour summary:
//   - channel c is free when it is empty or its consumer is taking the beat
//     this cycle; in_ready is the free status of the selected channel, or 1
//     for an out-of-range select
//   - a load and a drain on the same channel in one cycle keep the channel
//     full with the new beat, giving one beat per cycle sustained
//   - a stalled channel holds in_ready low for beats addressed to it, so the
//     producer waits and ordering stays strictly in-order
//   - 1-cycle latency; no combinational path from in_data to any output
// -----------------------------------------------------------------------------
module stream_demux #(
    parameter int WIDTH   = 8,
    parameter int NUM_OUT = 4,
    parameter int CNT_W   = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    stream_demux_if.slave io_bus
);
    // Derived from NUM_OUT; never set independently.
    localparam int SEL_W = $clog2(NUM_OUT);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [NUM_OUT-1:0] r_valid;
    logic [WIDTH-1:0]   r_data [NUM_OUT];
    logic [CNT_W-1:0]   r_drop_count;

    // -------------------------------------------------------------------------
    // Combinational decode
    // -------------------------------------------------------------------------
    logic [NUM_OUT-1:0] w_sel_hot;   // one-hot of in_sel (all zero if out of range)
    logic [NUM_OUT-1:0] w_free;      // channel can take a beat this cycle
    logic [NUM_OUT-1:0] w_load;      // channel loads in_data at this edge
    logic [NUM_OUT-1:0] w_drain;     // consumer takes the held beat at this edge
    logic               w_in_range;
    logic               w_accept;
    logic               w_drop;

    // When NUM_OUT is a power of two every select value is a real channel, and
    // the range compare would be a constant; only build it when it can fail.
    if (NUM_OUT == (1 << SEL_W)) begin : g_full_range
        assign w_in_range = 1'b1;
    end else begin : g_partial_range
        assign w_in_range = (io_bus.in_sel < SEL_W'(NUM_OUT));
    end

    always_comb begin
        // NOTE: give every combinational output a default before the loop so
        // no path leaves it unassigned, which would infer a latch.
        w_sel_hot = '0;
        for (int c = 0; c < NUM_OUT; c++) begin
            w_sel_hot[c] = (io_bus.in_sel == SEL_W'(c));
        end
    end

    // During reset the channels are treated as already cleared, so any
    // in-range select reports free; accepts in that cycle are ignored below.
    assign w_free   = ~r_valid | io_bus.out_ready | {NUM_OUT{i_rst}};
    assign w_drain  = r_valid & io_bus.out_ready;

    // Out-of-range beats are always taken so they never stall the producer.
    assign io_bus.in_ready = !w_in_range || ((w_sel_hot & w_free) != '0);

    assign w_accept = io_bus.in_valid && io_bus.in_ready && !i_rst;
    assign w_load   = w_sel_hot & {NUM_OUT{w_accept && w_in_range}};
    assign w_drop   = w_accept && !w_in_range;

    // -------------------------------------------------------------------------
    // Channel buffers and drop counter
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: the payload registers are cleared on reset because a
            // cleared out_data is part of the visible post-reset state, not
            // just the valid bits.
            r_valid      <= '0;
            r_drop_count <= '0;
            for (int c = 0; c < NUM_OUT; c++) begin
                r_data[c] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            // A load wins over a drain: drain+load keeps the channel full.
            r_valid <= (r_valid & ~w_drain) | w_load;

            for (int c = 0; c < NUM_OUT; c++) begin
                if (w_load[c]) begin
                    r_data[c] <= io_bus.in_data;
                end
            end

            if (w_drop && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign io_bus.out_valid  = r_valid;
    assign io_bus.drop_count = r_drop_count;

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        assign io_bus.out_data[g*WIDTH +: WIDTH] = r_data[g];

        // A held beat that the consumer is not taking must not move.
        a_out_stable : assert property (
            @(posedge i_clk) disable iff (i_rst)
            (r_valid[g] && !io_bus.out_ready[g]) |=> (r_valid[g] && $stable(r_data[g]))
        );
    end

    // Producer contract: a presented beat stays unchanged until it is taken.
    a_in_hold : assert property (
        @(posedge i_clk) disable iff (i_rst)
        (io_bus.in_valid && !io_bus.in_ready) |=>
            (io_bus.in_valid && $stable(io_bus.in_sel) && $stable(io_bus.in_data))
    );

endmodule

// File: tb/tb_stream_demux.sv
// -----------------------------------------------------------------------------
// tb_stream_demux
//
// Self-checking bench for stream_demux. A 4-channel instance is checked by a
// queue-based scoreboard: the driver pushes every accepted beat onto the queue
// of its channel, and a separate monitor process compares out_valid/out_data
// to the queue heads every cycle and pops on each consumer handshake. A
// 3-channel instance exercises out-of-range drops and counter saturation.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_stream_demux;
    localparam int W   = 8;
    localparam int N   = 4;
    localparam int N3  = 3;
    localparam int CW  = 8;
    localparam int TMO = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one queue of pending beats per channel, the last beat
    // loaded into each channel, and counts of beats sent and delivered.
    logic [W-1:0] exp_q [N][$];
    logic [W-1:0] last_data [N];
    int           exp_drop3    = 0;
    int           n_push       = 0;
    int           dut_deliv    = 0;
    int           last_acc_cyc = 0;
    bit           rand_done    = 1'b0;

    logic [W-1:0] basic [N] = '{8'h11, 8'h22, 8'h33, 8'h44};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stream_demux_if #(.WIDTH(W), .NUM_OUT(N),  .CNT_W(CW)) bus  ();
    stream_demux_if #(.WIDTH(W), .NUM_OUT(N3), .CNT_W(CW)) bus3 ();

    stream_demux #(.WIDTH(W), .NUM_OUT(N),  .CNT_W(CW)) dut  (.i_clk(clk), .i_rst(rst), .io_bus(bus));
    stream_demux #(.WIDTH(W), .NUM_OUT(N3), .CNT_W(CW)) dut3 (.i_clk(clk), .i_rst(rst), .io_bus(bus3));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat to the 4-channel instance and hold it until the model
    // says the target channel is free (queue empty after this cycle's drain).
    task automatic send(input int sel, input logic [W-1:0] data);
        bit   done = 1'b0;
        logic exp_rdy;
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'(sel);
        bus.in_data  = data;
        for (int t = 0; t < TMO && !done; t++) begin
            @(negedge clk);
            #1;
            exp_rdy = (exp_q[sel].size() == 0);
            check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            if (exp_rdy) begin
                exp_q[sel].push_back(data);
                last_data[sel] = data;
                last_acc_cyc   = cyc;
                n_push++;
                done = 1'b1;
            end
            step();
        end
        if (!done) check("accept timeout", 32'd0, 32'd1);
        // Idle bus carries junk that must be ignored.
        bus.in_valid = 1'b0;
        bus.in_sel   = 2'($urandom);
        bus.in_data  = 8'($urandom);
    endtask

    // One-cycle reset; buffered beats are discarded from the model as well.
    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus3.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < N; c++) begin
            n_push -= exp_q[c].size();
            exp_q[c].delete();
            last_data[c] = '0;
        end
        exp_drop3 = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rel_cyc;
        int start;
        int first;
        int hol0;
        int hol1;

        bus.in_valid   = 1'b0;
        bus.in_sel     = '0;
        bus.in_data    = '0;
        bus.out_ready  = '0;
        bus3.in_valid  = 1'b0;
        bus3.in_sel    = '0;
        bus3.in_data   = '0;
        bus3.out_ready = '0;
        for (int c = 0; c < N; c++) last_data[c] = '0;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Scoreboard monitor: compares every channel against its queue head,
        // counts real handshakes, and retires beats the consumer takes.
        fork
            forever begin
                @(negedge clk);
                for (int c = 0; c < N; c++) begin
                    check($sformatf("out_valid[%0d]", c), 32'(bus.out_valid[c]),
                          32'(exp_q[c].size() != 0));
                    if (exp_q[c].size() != 0)
                        check($sformatf("out_data[%0d]", c), 32'(bus.out_data[c*W +: W]),
                              32'(exp_q[c][0]));
                    else
                        check($sformatf("held out_data[%0d]", c), 32'(bus.out_data[c*W +: W]),
                              32'(last_data[c]));
                    if (bus.out_valid[c] && bus.out_ready[c]) dut_deliv++;
                    if (exp_q[c].size() != 0 && bus.out_ready[c]) void'(exp_q[c].pop_front());
                end
                check("drop_count n4", 32'(bus.drop_count), 32'd0);
            end
        join_none

        // Reset state of both instances.
        @(negedge clk);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst out_data", 32'(bus.out_data), 32'd0);
        check("rst out_valid n3", 32'(bus3.out_valid), 32'd0);
        check("rst drop n3", 32'(bus3.drop_count), 32'd0);
        step();

        // Basic steering: one beat per channel, all consumers ready.
        bus.out_ready = '1;
        for (int i = 0; i < N; i++) send(i, basic[i]);
        repeat (2) step();
        @(negedge clk);
        for (int c = 0; c < N; c++)
            check($sformatf("basic data[%0d]", c), 32'(bus.out_data[c*W +: W]), 32'(basic[c]));
        check("basic idle valid", 32'(bus.out_valid), 32'd0);
        step();

        // Stall channel 2, queue a second beat, then release the consumer.
        bus.out_ready = 4'b1011;
        send(2, 8'hA5);
        fork
            send(2, 8'h5A);
            begin
                repeat (4) step();
                bus.out_ready[2] = 1'b1;
                rel_cyc = cyc;
            end
        join
        check("stall accept cycle", 32'(last_acc_cyc), 32'(rel_cyc));
        @(negedge clk);
        check("stall valid[2]", 32'(bus.out_valid[2]), 32'd1);
        check("stall data[2]", 32'(bus.out_data[2*W +: W]), 32'h5A);
        step();

        // Back-to-back: 8 distinct beats to channel 1 in 8 consecutive cycles.
        bus.out_ready = '1;
        send(1, 8'h03);
        first = last_acc_cyc;
        for (int i = 1; i < 8; i++) send(1, 8'(i * 17 + 3));
        check("b2b span", 32'(last_acc_cyc - first), 32'd7);

        // Out-of-range selects on the 3-channel instance.
        bus3.out_ready = '1;
        for (int i = 0; i < 3; i++) begin
            bus3.in_valid = 1'b1;
            bus3.in_sel   = 2'd3;
            bus3.in_data  = 8'($urandom);
            @(negedge clk);
            check("n3 drop in_ready", 32'(bus3.in_ready), 32'd1);
            check("n3 drop out_valid", 32'(bus3.out_valid), 32'd0);
            step();
            exp_drop3 = (exp_drop3 < 255) ? exp_drop3 + 1 : 255;
        end
        bus3.in_valid = 1'b0;
        @(negedge clk);
        check("n3 drop_count 3", 32'(bus3.drop_count), 32'(exp_drop3));
        check("n3 out_data quiet", 32'(bus3.out_data), 32'd0);
        step();
        bus3.in_valid = 1'b1;
        bus3.in_sel   = 2'd3;
        for (int i = 0; i < 253; i++) begin
            step();
            exp_drop3 = (exp_drop3 < 255) ? exp_drop3 + 1 : 255;
        end
        bus3.in_sel = 2'd1;
        bus3.in_data = 8'h3C;
        @(negedge clk);
        check("n3 drop_count 255", 32'(bus3.drop_count), 32'(exp_drop3));
        check("n3 in-range ready", 32'(bus3.in_ready), 32'd1);
        step();
        bus3.in_valid = 1'b0;
        @(negedge clk);
        check("n3 ch1 valid", 32'(bus3.out_valid), 32'b010);
        check("n3 ch1 data", 32'(bus3.out_data[1*W +: W]), 32'h3C);
        check("n3 saturated", 32'(bus3.drop_count), 32'd255);
        step();

        // Reset with beats stalled on channels 0 and 3.
        bus.out_ready = 4'b0110;
        send(0, 8'hC0);
        send(3, 8'h3F);
        @(negedge clk);
        check("pre-rst valid", 32'(bus.out_valid), 32'b1001);
        step();
        do_reset();
        @(negedge clk);
        check("post-rst valid", 32'(bus.out_valid), 32'd0);
        check("post-rst data", 32'(bus.out_data), 32'd0);
        check("post-rst drop n3", 32'(bus3.drop_count), 32'd0);
        check("post-rst data n3", 32'(bus3.out_data), 32'd0);
        step();
        start = cyc;
        send(0, 8'h77);
        check("post-rst accept", 32'(last_acc_cyc), 32'(start));

        // Head-of-line: channel 0 stalled, a sel=0 beat then a sel=1 beat.
        bus.out_ready = 4'b1110;
        fork
            begin
                send(0, 8'h81);
                hol0 = last_acc_cyc;
                send(1, 8'h82);
                hol1 = last_acc_cyc;
            end
            begin
                repeat (5) step();
                bus.out_ready[0] = 1'b1;
                rel_cyc = cyc;
            end
        join
        check("hol sel0 accept", 32'(hol0), 32'(rel_cyc));
        check("hol sel1 accept", 32'(hol1), 32'(rel_cyc + 1));

        // Random traffic against random consumer back-pressure.
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(3) == 0) step();
                    send($urandom_range(N - 1), 8'($urandom));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    step();
                    bus.out_ready = 4'($urandom);
                end
            end
        join

        // Drain everything and reconcile beats sent against beats delivered.
        bus.out_ready = '1;
        repeat (3) step();
        @(negedge clk);
        check("final idle", 32'(bus.out_valid), 32'd0);
        check("beats delivered", 32'(dut_deliv), 32'(n_push));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
